// File: rtl/multdiv_ctrl.sv
// Issue/writeback controller for the multdiv unit: one mult/div in flight, start pulse, watchdog, result writeback.
// Latency: accept -> wb_valid is 3 cycles minimum (RDY in first BUSY cycle), TIMEOUT+2 cycles on watchdog expiry.
// Backpressure: in_ready/stall hold off execute until the wb_valid/wb_ready handshake; wb_* held stable while wb_ready=0.
//
// Ports:
//   clock, reset (async, active-low)
//   in_valid/in_ready, in_mult, in_div, in_opA, in_opB, in_rd : instruction issue from execute
//   stall                                                     : pipeline stall, high outside IDLE
//   data_operandA/B, ctrl_MULT, ctrl_DIV                      : operands and one-cycle start pulse to multdiv
//   data_result, data_exception, data_resultRDY               : completion from multdiv
//   wb_valid/wb_ready, wb_data, wb_rd, wb_exception           : writeback request
module multdiv_ctrl #(
    parameter int TIMEOUT     = 64,
    parameter int EXC_RD      = 30,
    parameter int EXC_MULT    = 4,
    parameter int EXC_DIV     = 5,
    parameter int EXC_TIMEOUT = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_mult,
    input  logic        in_div,
    input  logic [31:0] in_opA,
    input  logic [31:0] in_opB,
    input  logic [4:0]  in_rd,
    output logic        in_ready,
    output logic        stall,
    output logic [31:0] data_operandA,
    output logic [31:0] data_operandB,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    input  logic [31:0] data_result,
    input  logic        data_exception,
    input  logic        data_resultRDY,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_exception
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wd_cnt;
    logic             op_mult;
    logic [4:0]       rd_q;
    logic             accept;
    logic             wd_expired;

    // Exactly one op select must be high; anything else is silently dropped.
    assign accept     = (state == IDLE) && in_valid && (in_mult ^ in_div);
    // Counter is 0 in BUSY cycle 1, so TIMEOUT-1 marks the last BUSY cycle.
    assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and all control outputs decode from state (plus latched op type) only.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        stall     = 1'b1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        wb_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                stall    = 1'b0;
                if (accept) state_nxt = START;
            end
            START: begin
                // RDY may still be high from the previous op; it is not looked at here.
                ctrl_MULT = op_mult;
                ctrl_DIV  = !op_mult;
                state_nxt = BUSY;
            end
            BUSY: begin
                if (data_resultRDY || wd_expired) state_nxt = DONE;
            end
            DONE: begin
                wb_valid = 1'b1;
                if (wb_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_operandA <= '0;
            data_operandB <= '0;
            rd_q          <= '0;
            op_mult       <= 1'b0;
            wd_cnt        <= '0;
            wb_data       <= '0;
            wb_rd         <= '0;
            wb_exception  <= 1'b0;
        end else begin
            if (accept) begin
                data_operandA <= in_opA;
                data_operandB <= in_opB;
                rd_q          <= in_rd;
                op_mult       <= in_mult;
            end
            if (state == START) begin
                wd_cnt <= '0;
            end
            if (state == BUSY) begin
                wd_cnt <= wd_cnt + CNT_W'(1);
                // RDY takes priority over a coincident watchdog expiry.
                if (data_resultRDY) begin
                    if (data_exception) begin
                        wb_data      <= op_mult ? 32'(EXC_MULT) : 32'(EXC_DIV);
                        wb_rd        <= 5'(EXC_RD);
                        wb_exception <= 1'b1;
                    end else begin
                        wb_data      <= data_result;
                        wb_rd        <= rd_q;
                        wb_exception <= 1'b0;
                    end
                end else if (wd_expired) begin
                    wb_data      <= 32'(EXC_TIMEOUT);
                    wb_rd        <= 5'(EXC_RD);
                    wb_exception <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
module tb_multdiv_ctrl;

    localparam int TMO = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, in_mult = 1'b0, in_div = 1'b0;
    logic [31:0] in_opA = '0, in_opB = '0;
    logic [4:0]  in_rd = '0;
    logic        in_ready, stall, ctrl_MULT, ctrl_DIV;
    logic [31:0] data_operandA, data_operandB;
    logic [31:0] data_result = '0;
    logic        data_exception = 1'b0, data_resultRDY = 1'b0;
    logic        wb_valid, wb_exception;
    logic        wb_ready = 1'b0;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;

    multdiv_ctrl #(.TIMEOUT(TMO), .EXC_RD(30), .EXC_MULT(4), .EXC_DIV(5), .EXC_TIMEOUT(7)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_mult(in_mult), .in_div(in_div),
        .in_opA(in_opA), .in_opB(in_opB), .in_rd(in_rd),
        .in_ready(in_ready), .stall(stall),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_result(data_result), .data_exception(data_exception), .data_resultRDY(data_resultRDY),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_exception(wb_exception)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        mult;
        logic        div;
        logic [31:0] opA;
        logic [31:0] opB;
        logic [4:0]  rd;
        int          dly;      // RDY driven in BUSY cycle dly; 0 = never
        logic        stale;    // drive a stale RDY during START
        logic [31:0] md_res;
        logic        md_exc;
        int          bp;       // cycles wb_ready held low once wb_valid is up
        logic [31:0] exp_data;
        logic [4:0]  exp_rd;
        logic        exp_exc;
        int          exp_lat;  // acceptance -> wb_valid, in cycles
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        exc;
    } wb_t;

    vec_t tbl[10];
    wb_t  sb_q[$];
    int   passed = 0;
    int   total  = 0;
    int   mult_pulses = 0;
    int   div_pulses  = 0;
    int   both_seen   = 0;

    // Start-pulse monitor: outputs only change at posedge, so negedge sampling is stable.
    always @(negedge clock) begin
        if (ctrl_MULT) mult_pulses = mult_pulses + 1;
        if (ctrl_DIV)  div_pulses  = div_pulses + 1;
        if (ctrl_MULT && ctrl_DIV) both_seen = both_seen + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Called and returns at a negedge.
    task automatic run_vec(input int idx, input vec_t v);
        int          m0, d0, cyc, stall_bad, bp_bad;
        logic [31:0] prev_a;
        wb_t         e;
        m0 = mult_pulses;
        d0 = div_pulses;
        if (v.mult == v.div) begin
            prev_a   = data_operandA;
            in_valid = 1'b1; in_mult = v.mult; in_div = v.div;
            in_opA = v.opA; in_opB = v.opB; in_rd = v.rd;
            stall_bad = 0;
            repeat (3) begin
                @(negedge clock);
                if (stall || !in_ready) stall_bad++;
            end
            in_valid = 1'b0; in_mult = 1'b0; in_div = 1'b0;
            check($sformatf("v%0d illegal not accepted", idx), stall_bad, 0);
            check($sformatf("v%0d illegal no latch", idx), data_operandA, prev_a);
            check($sformatf("v%0d illegal no pulse", idx), (mult_pulses - m0) + (div_pulses - d0), 0);
            return;
        end
        check($sformatf("v%0d in_ready before issue", idx), in_ready, 1);
        in_valid = 1'b1; in_mult = v.mult; in_div = v.div;
        in_opA = v.opA; in_opB = v.opB; in_rd = v.rd;
        sb_q.push_back('{v.exp_data, v.exp_rd, v.exp_exc});
        @(negedge clock);
        in_valid = 1'b0; in_mult = 1'b0; in_div = 1'b0;
        // START cycle
        check($sformatf("v%0d ctrl_MULT in START", idx), ctrl_MULT, v.mult);
        check($sformatf("v%0d ctrl_DIV in START", idx), ctrl_DIV, v.div);
        check($sformatf("v%0d operandA", idx), data_operandA, v.opA);
        check($sformatf("v%0d operandB", idx), data_operandB, v.opB);
        cyc = 1;
        stall_bad = (stall !== 1'b1) ? 1 : 0;
        while (!wb_valid && cyc < 200) begin
            if (v.stale && cyc == 1) begin
                data_resultRDY = 1'b1; data_result = 32'hBAD0_0BAD; data_exception = 1'b0;
            end else if (v.dly != 0 && cyc == v.dly + 1) begin
                data_resultRDY = 1'b1; data_result = v.md_res; data_exception = v.md_exc;
            end else begin
                data_resultRDY = 1'b0;
            end
            @(negedge clock);
            cyc++;
            if (stall !== 1'b1) stall_bad++;
        end
        data_resultRDY = 1'b0;
        check($sformatf("v%0d latency", idx), cyc, v.exp_lat);
        check($sformatf("v%0d stall while busy", idx), stall_bad, 0);
        if (sb_q.size() == 0) begin
            check($sformatf("v%0d scoreboard empty", idx), 1, 0);
            return;
        end
        e = sb_q.pop_front();
        check($sformatf("v%0d wb_data", idx), wb_data, e.data);
        check($sformatf("v%0d wb_rd", idx), wb_rd, e.rd);
        check($sformatf("v%0d wb_exception", idx), wb_exception, e.exc);
        if (v.bp > 0) begin
            bp_bad = 0;
            repeat (v.bp) begin
                @(negedge clock);
                if (!wb_valid || !stall || wb_data !== e.data || wb_rd !== e.rd || wb_exception !== e.exc)
                    bp_bad++;
            end
            check($sformatf("v%0d wb held under backpressure", idx), bp_bad, 0);
        end
        wb_ready = 1'b1;
        @(negedge clock);
        wb_ready = 1'b0;
        check($sformatf("v%0d in_ready after handshake", idx), in_ready, 1);
        check($sformatf("v%0d wb_valid after handshake", idx), wb_valid, 0);
        check($sformatf("v%0d MULT pulses", idx), mult_pulses - m0, v.mult);
        check($sformatf("v%0d DIV pulses", idx), div_pulses - d0, v.div);
    endtask

    initial begin
        vec_t r;
        int   m0;
        //        mult  div   opA          opB          rd  dly stale md_res        exc  bp  exp_d exp_rd exc lat
        tbl[0] = '{1'b1, 1'b0, 32'd6,       32'd7,       5'd3, 17, 1'b0, 32'd42,       1'b0, 0,  32'd42, 5'd3,  1'b0, 19};
        tbl[1] = '{1'b0, 1'b1, 32'd100,     32'd7,       5'd9, 5,  1'b0, 32'd14,       1'b0, 0,  32'd14, 5'd9,  1'b0, 7};
        tbl[2] = '{1'b0, 1'b1, 32'd5,       32'd0,       5'd2, 3,  1'b0, 32'hDEAD,     1'b1, 0,  32'd5,  5'd30, 1'b1, 5};
        tbl[3] = '{1'b1, 1'b0, 32'h10000,   32'h10000,   5'd4, 8,  1'b0, 32'd0,        1'b1, 0,  32'd4,  5'd30, 1'b1, 10};
        tbl[4] = '{1'b1, 1'b0, 32'd1,       32'd1,       5'd7, 0,  1'b1, 32'd0,        1'b0, 0,  32'd7,  5'd30, 1'b1, 66};
        tbl[5] = '{1'b1, 1'b0, 32'd2,       32'd3,       5'd0, 1,  1'b0, 32'd6,        1'b0, 10, 32'd6,  5'd0,  1'b0, 3};
        tbl[6] = '{1'b1, 1'b1, 32'hAAAA,    32'hBBBB,    5'd1, 1,  1'b0, 32'd0,        1'b0, 0,  32'd0,  5'd0,  1'b0, 0};
        tbl[7] = '{1'b0, 1'b0, 32'hCCCC,    32'hDDDD,    5'd1, 1,  1'b0, 32'd0,        1'b0, 0,  32'd0,  5'd0,  1'b0, 0};
        tbl[8] = '{1'b1, 1'b0, 32'd9,       32'd9,       5'd5, 64, 1'b0, 32'd81,       1'b0, 0,  32'd81, 5'd5,  1'b0, 66};
        tbl[9] = '{1'b0, 1'b1, 32'd77,      32'd11,      5'd31, 2, 1'b0, 32'd7,        1'b0, 3,  32'd7,  5'd31, 1'b0, 4};

        repeat (2) @(negedge clock);
        check("reset in_ready", in_ready, 1);
        check("reset stall", stall, 0);
        check("reset ctrl", {ctrl_MULT, ctrl_DIV}, 0);
        check("reset wb_valid", wb_valid, 0);
        check("reset wb_data", wb_data, 0);
        check("reset wb_rd/exc", {wb_rd, wb_exception}, 0);
        check("reset operands", data_operandA | data_operandB, 0);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 10; i++) run_vec(i, tbl[i]);
        check("never both ctrl", both_seen, 0);

        // Async reset in BUSY cycle 5 of a multiply.
        m0 = mult_pulses;
        in_valid = 1'b1; in_mult = 1'b1; in_div = 1'b0;
        in_opA = 32'd11; in_opB = 32'd13; in_rd = 5'd6;
        @(negedge clock);
        in_valid = 1'b0; in_mult = 1'b0;
        repeat (5) @(negedge clock);
        check("pre-reset stall", stall, 1);
        reset = 1'b0;
        #1;
        check("async reset stall", stall, 0);
        check("async reset in_ready", in_ready, 1);
        check("async reset wb_valid/ctrl", {wb_valid, ctrl_MULT, ctrl_DIV}, 0);
        check("async reset operandA", data_operandA, 0);
        check("aborted op pulses", mult_pulses - m0, 1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        r = '{1'b1, 1'b0, 32'd3, 32'd4, 5'd8, 4, 1'b0, 32'd12, 1'b0, 0, 32'd12, 5'd8, 1'b0, 6};
        run_vec(10, r);
        check("scoreboard drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Issue/writeback controller between the execute stage and the `multdiv` unit. It accepts one multiply or divide instruction at a time, holds the operands stable, and pulses the `ctrl_MULT`/`ctrl_DIV` start line for exactly one cycle. It waits for `data_resultRDY`, or for a watchdog timeout, then presents the result or an rstatus exception write to writeback under a valid/ready handshake. The pipeline is stalled from acceptance until writeback completes.

## Interface
- `TIMEOUT`, 64 — BUSY cycles without `data_resultRDY` before a timeout exception is raised (≥2).
- `EXC_RD`, 30 — destination register used for every exception writeback.
- `EXC_MULT`, 4 — rstatus code for a multiply exception.
- `EXC_DIV`, 5 — rstatus code for a divide exception.
- `EXC_TIMEOUT`, 7 — rstatus code for a watchdog timeout.
- `clock` in 1 — single clock; all state updates on the rising edge.
- `reset` in 1 — asynchronous, active-low; 0 forces reset state immediately.
- `in_valid` in 1 — execute stage presents an instruction.
- `in_mult`, `in_div` in 1 each — operation select; exactly one may be high.
- `in_opA`, `in_opB` in 32 each — operands.
- `in_rd` in 5 — destination register.
- `in_ready` out 1 — high only in IDLE.
- `stall` out 1 — high in every state except IDLE.
- `data_operandA`, `data_operandB` out 32 each — latched operands to `multdiv`.
- `ctrl_MULT`, `ctrl_DIV` out 1 each — one-cycle start pulses to `multdiv`.
- `data_result` in 32 — result from `multdiv`.
- `data_exception` in 1 — exception flag from `multdiv`.
- `data_resultRDY` in 1 — ready flag from `multdiv`.
- `wb_valid` out 1 — writeback request.
- `wb_ready` in 1 — writeback accepts.
- `wb_data` out 32 — data to write.
- `wb_rd` out 5 — register to write.
- `wb_exception` out 1 — writeback carries an exception code.

## Operation
- FSM states: IDLE, START, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - Accept on `in_valid & in_ready & (in_mult ^ in_div)`.
  - On accept, latch opA, opB, rd and op type, then go to START.
  - `in_valid` with both ops high, or neither high, is ignored. State stays IDLE; nothing is latched.
- START:
  - Drive `ctrl_MULT` (mult) or `ctrl_DIV` (div) high for this cycle only. Never drive both.
  - Clear the watchdog counter. Go to BUSY.
  - `data_resultRDY` is ignored in START, because it can be stale from the previous operation.
- BUSY:
  - Counter increments every cycle.
  - If `data_resultRDY`=1, capture `data_result` and `data_exception`, then go to DONE.
  - Otherwise, if the counter reaches `TIMEOUT`-1, go to DONE with a timeout. RDY wins if both occur in the same cycle.
- Capture mapping:
  - Normal completion: `wb_data`=result, `wb_rd`=latched rd, `wb_exception`=0.
  - `data_exception`: `wb_data`=`EXC_MULT` or `EXC_DIV` by op type, `wb_rd`=`EXC_RD`, `wb_exception`=1.
  - Timeout: `wb_data`=`EXC_TIMEOUT`, `wb_rd`=`EXC_RD`, `wb_exception`=1.
- DONE:
  - `wb_valid`=1. `wb_data`/`wb_rd`/`wb_exception` are held stable.
  - On `wb_ready`=1, return to IDLE.
  - `multdiv` inputs are ignored in DONE.
- Register 0 destination: no special case; writeback still occurs and the regfile discards it.
- `data_operandA`/`data_operandB` hold the latched values from acceptance until the next acceptance.

## Timing
- Reset values:
  - All outputs 0, except `in_ready`=1 (IDLE).
  - Latched operands, wb registers and counter are 0.
- Reset asserted mid-operation: return to IDLE asynchronously. `ctrl_*` and `wb_valid` drop immediately; captured results are discarded.
- Cycle sequence for an instruction accepted at edge E:
  - START occupies the cycle after E (`ctrl_*` high, `stall`=1).
  - BUSY begins the following cycle.
  - If RDY is sampled in BUSY cycle k (k≥1), `wb_valid` rises the next cycle.
- Minimum acceptance-to-`wb_valid` latency: 3 cycles.
- Timeout: `wb_valid` rises `TIMEOUT`+2 cycles after acceptance.
- Handshake completes on the edge with `wb_valid & wb_ready`.
  - `in_ready` is high in the following cycle, so back-to-back issue costs one idle cycle.
- All outputs are registered or decoded from state only. There is no combinational path from `data_*` inputs to `wb_*` outputs.

## Test plan
- Mult basic: opA=6, opB=7, rd=3; `multdiv` model returns 42 with RDY 17 cycles after the pulse.
  - Required: one `ctrl_MULT` pulse; `wb_valid`, `wb_data`=42, `wb_rd`=3, `wb_exception`=0; `stall` high throughout.
- Div basic: opA=100, opB=7, rd=9; result 14.
  - Required: one `ctrl_DIV` pulse with `ctrl_MULT`=0; `wb_data`=14, `wb_rd`=9.
- Exceptions:
  - Divide 5/0 with `data_exception`=1: required `wb_rd`=30, `wb_data`=5, `wb_exception`=1.
  - Multiply 0x10000×0x10000 with overflow: required `wb_data`=4.
- Watchdog: hold RDY=0 with `TIMEOUT`=64.
  - Required: `wb_valid` 66 cycles after acceptance, `wb_data`=7, `wb_rd`=30.
  - Also: stale RDY=1 during START is ignored.
- Backpressure and illegal input:
  - `wb_ready` held 0 for 10 cycles: `wb_*` stable and `stall` stays high.
  - `in_mult`=`in_div`=1 in IDLE: not accepted.
- Async reset in BUSY cycle 5: outputs clear before the next edge and the FSM is in IDLE.
  - A new multiply, 3×4, issued after reset releases returns 12.
